// File: rtl/gcd_sched_pkg.sv
// Shared types and defaults for the round-robin GCD scheduler.
package gcd_sched_pkg;

  localparam int unsigned SIZE_DEF  = 8;
  localparam int unsigned N_REQ_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LDA,
    LDB,
    WAIT,
    RESP,
    CLR
  } state_e;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Round-robin grant: combinational pick from the pointer upward with wrap,
// pointer advances past the winner when the grant is taken.
module gcd_rr_arbiter
  import gcd_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic             i_update,
  output logic             o_gnt_vld,
  output logic [ID_W-1:0]  o_gnt_idx,
  output logic [N_REQ-1:0] o_gnt_onehot
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_gnt_vld    = 1'b0;
    o_gnt_idx    = '0;
    o_gnt_onehot = '0;
    w_sum        = '0;
    w_idx        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!o_gnt_vld && i_req_valid[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_idx;
      end
    end
    if (o_gnt_vld) begin
      o_gnt_onehot[o_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_update && o_gnt_vld) begin
      r_ptr <= (o_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : o_gnt_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Shares one subtractive GCD unit among N_REQ requesters, one job at a time.
// Optional watchdog on the WAIT state: define GCD_SCHED_TIMEOUT_EN.
module gcd_rr_scheduler
  import gcd_sched_pkg::*;
#(
  parameter int unsigned SIZE           = SIZE_DEF,
  parameter int unsigned N_REQ          = N_REQ_DEF,
  parameter int unsigned ID_W           = id_width(N_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 300
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*SIZE-1:0] req_a,
  input  logic [N_REQ*SIZE-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [SIZE-1:0]       rsp_data,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic                  gcd_start,
  output logic                  gcd_reset,
  output logic [SIZE-1:0]       gcd_data_in,
  input  logic [SIZE-1:0]       gcd_data_out,
  input  logic                  gcd_done,
  output logic                  busy
);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("gcd_rr_scheduler: unsupported parameter set");
  end

  state_e           r_state;
  logic [SIZE-1:0]  r_a;
  logic [SIZE-1:0]  r_b;
  logic [ID_W-1:0]  r_rsp_id;
  logic [SIZE-1:0]  r_rsp_data;
  logic             r_rsp_valid;
  logic             r_gcd_start;
  logic [SIZE-1:0]  r_gcd_data_in;
  logic             r_clr_q;
  logic             r_busy;
  logic             r_bypass;

  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [N_REQ-1:0] w_gnt_onehot;
  logic             w_take;
  logic [SIZE-1:0]  w_a;
  logic [SIZE-1:0]  w_b;

  gcd_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .i_update     (w_take),
    .o_gnt_vld    (w_gnt_vld),
    .o_gnt_idx    (w_gnt_idx),
    .o_gnt_onehot (w_gnt_onehot)
  );

  // Accept is a same-cycle handshake, so it cannot be delayed a cycle.
  assign w_take    = (r_state == IDLE) && w_gnt_vld && !reset;
  assign req_ready = w_take ? w_gnt_onehot : '0;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_a = req_a[i*SIZE +: SIZE];
        w_b = req_b[i*SIZE +: SIZE];
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign gcd_start   = r_gcd_start;
  assign gcd_data_in = r_gcd_data_in;
  assign gcd_reset   = reset | r_clr_q;
  assign busy        = r_busy;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  // Outputs are loaded on the transition so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_rsp_id      <= '0;
      r_rsp_data    <= '0;
      r_rsp_valid   <= 1'b0;
      r_gcd_start   <= 1'b0;
      r_gcd_data_in <= '0;
      r_clr_q       <= 1'b0;
      r_busy        <= 1'b0;
      r_bypass      <= 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
      r_wd_cnt      <= '0;
      r_rsp_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_a      <= w_a;
            r_b      <= w_b;
            r_rsp_id <= w_gnt_idx;
            r_busy   <= 1'b1;
`ifdef GCD_SCHED_TIMEOUT_EN
            r_rsp_err <= 1'b0;
`endif
            // A zero operand would never terminate in the subtractive unit.
            if (w_a == '0 || w_b == '0) begin
              r_bypass    <= 1'b1;
              r_rsp_data  <= w_a | w_b;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_bypass    <= 1'b0;
              r_gcd_start <= 1'b1;
              r_state     <= START;
            end
          end
        end
        START: begin
          r_gcd_start   <= 1'b0;
          r_gcd_data_in <= r_a;
          r_state       <= LDA;
        end
        LDA: begin
          r_gcd_data_in <= r_b;
          r_state       <= LDB;
        end
        LDB: begin
          r_gcd_data_in <= '0;
`ifdef GCD_SCHED_TIMEOUT_EN
          r_wd_cnt      <= '0;
`endif
          r_state       <= WAIT;
        end
        WAIT: begin
          if (gcd_done) begin
            r_rsp_data  <= gcd_data_out;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
`ifdef GCD_SCHED_TIMEOUT_EN
          else if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_bypass) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_clr_q <= 1'b1;
              r_state <= CLR;
            end
          end
        end
        CLR: begin
          r_clr_q <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler with a behavioural subtractive GCD unit attached.
// Build with +define+GCD_SCHED_TIMEOUT_EN to add the watchdog scenario.
module tb_gcd_rr_scheduler;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  logic                  clk;
  logic                  reset;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*SIZE-1:0] req_a;
  logic [N_REQ*SIZE-1:0] req_b;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [SIZE-1:0]       rsp_data;
  logic                  rsp_err;
  logic                  rsp_ready;
  logic                  gcd_start;
  logic                  gcd_reset;
  logic [SIZE-1:0]       gcd_data_in;
  logic [SIZE-1:0]       gcd_data_out;
  logic                  gcd_done;
  logic                  busy;

  gcd_rr_scheduler #(
    .SIZE           (SIZE),
    .N_REQ          (N_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .rsp_ready    (rsp_ready),
    .gcd_start    (gcd_start),
    .gcd_reset    (gcd_reset),
    .gcd_data_in  (gcd_data_in),
    .gcd_data_out (gcd_data_out),
    .gcd_done     (gcd_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural GCD unit: start, load A, load B, subtract until equal.
  logic [2:0] m_st;
  logic [7:0] m_a, m_b;
  always @(posedge clk) begin
    if (gcd_reset) begin
      m_st <= 3'd0; gcd_done <= 1'b0; gcd_data_out <= 8'd0; m_a <= 8'd0; m_b <= 8'd0;
    end else begin
      case (m_st)
        3'd0: if (gcd_start) m_st <= 3'd1;
        3'd1: begin m_a <= gcd_data_in; m_st <= 3'd2; end
        3'd2: begin m_b <= gcd_data_in; m_st <= 3'd3; end
        3'd3: begin
          if (m_a == m_b) begin gcd_done <= 1'b1; gcd_data_out <= m_a; m_st <= 3'd4; end
          else if (m_a > m_b) m_a <= m_a - m_b;
          else m_b <= m_b - m_a;
        end
        default: ;
      endcase
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] jobs [N_REQ][$];
  logic [10:0] exp_q[$];
  int          gnt_log[$];
  bit          exp_to = 1'b0;
  bit          saw_start = 1'b0;

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  task automatic add_job(input int r, input logic [7:0] a, input logic [7:0] b);
    jobs[r].push_back({a, b});
  endtask

  // Requesters hold valid with the head of their job list.
  logic [15:0] drv_j;
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N_REQ; i++) begin
      if (jobs[i].size() != 0) begin
        drv_j = jobs[i][0];
        req_valid[i] = 1'b1;
        req_a[i*SIZE +: SIZE] = drv_j[15:8];
        req_b[i*SIZE +: SIZE] = drv_j[7:0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // Scoreboard: push on grant, pop and compare on response handshake.
  int          mon_idx;
  logic [15:0] mon_j;
  logic [10:0] mon_e;
  always @(negedge clk) begin
    if (gcd_start) saw_start = 1'b1;
    if (!reset && req_ready != '0) begin
      n_vec++;
      mon_idx = 0;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) mon_idx = i;
      if (!$onehot(req_ready) || jobs[mon_idx].size() == 0) begin
        n_err++;
        $display("FAIL grant_legal: req_ready=%b pending=%0d", req_ready, jobs[mon_idx].size());
      end else begin
        mon_j = jobs[mon_idx].pop_front();
        gnt_log.push_back(mon_idx);
        if (exp_to) begin
          exp_q.push_back({2'(mon_idx), 8'd0, 1'b1});
          exp_to = 1'b0;
        end else begin
          exp_q.push_back({2'(mon_idx), gcd_ref(mon_j[15:8], mon_j[7:0]), 1'b0});
        end
      end
    end
    if (!reset && rsp_valid && rsp_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: id=%0d data=%0d err=%0d", rsp_id, rsp_data, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_id, rsp_data, rsp_err} !== mon_e) begin
          n_err++;
          $display("FAIL rsp_payload: got id=%0d data=%0d err=%0d want id=%0d data=%0d err=%0d",
                   rsp_id, rsp_data, rsp_err, mon_e[10:9], mon_e[8:1], mon_e[0]);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int k;
    bit pend;
    k = 0;
    pend = 1'b1;
    while (pend && k < 2000) begin
      pend = busy || (exp_q.size() != 0);
      for (int i = 0; i < N_REQ; i++) if (jobs[i].size() != 0) pend = 1'b1;
      if (pend) begin @(negedge clk); k++; end
    end
    n_vec++;
    if (pend) begin n_err++; $display("FAIL %s_drain: still busy after %0d cycles", nm, k); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy, rsp_valid, rsp_id, rsp_data, rsp_err, gcd_start, gcd_data_in, req_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b rv=%b id=%0d data=%0d err=%b start=%b din=%0d rdy=%b (want all 0)",
               busy, rsp_valid, rsp_id, rsp_data, rsp_err, gcd_start, gcd_data_in, req_ready);
    end
    n_vec++;
    if (gcd_reset !== 1'b1) begin n_err++; $display("FAIL reset_gcd_reset: got %b want 1", gcd_reset); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (gcd_reset !== 1'b0) begin n_err++; $display("FAIL reset_release: gcd_reset=%b want 0", gcd_reset); end
  endtask

  task automatic test_single();
    int k;
    @(posedge clk); #1 add_job(0, 8'd12, 8'd18);
    k = 0;
    do begin @(negedge clk); k++; end while (gcd_start !== 1'b1 && k < 20);
    n_vec++;
    if (gcd_start !== 1'b1) begin n_err++; $display("FAIL single_start: no gcd_start in %0d cycles", k); end
    @(negedge clk);
    n_vec++;
    if (gcd_data_in !== 8'd12 || gcd_start !== 1'b0) begin
      n_err++; $display("FAIL single_lda: din=%0d start=%b want 12/0", gcd_data_in, gcd_start);
    end
    @(negedge clk);
    n_vec++;
    if (gcd_data_in !== 8'd18) begin n_err++; $display("FAIL single_ldb: din=%0d want 18", gcd_data_in); end
    k = 0;
    while (rsp_valid !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    n_vec++;
    if (rsp_id !== 2'd0 || rsp_data !== 8'd6 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: id=%0d data=%0d err=%b want 0/6/0", rsp_id, rsp_data, rsp_err);
    end
    @(negedge clk);
    n_vec++;
    if (gcd_reset !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_clr: gcd_reset=%b rv=%b want 1/0", gcd_reset, rsp_valid);
    end
    @(negedge clk);
    n_vec++;
    if (gcd_reset !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_idle: gcd_reset=%b busy=%b want 0/0", gcd_reset, busy);
    end
  endtask

  task automatic test_round_robin();
    int want [5];
    want = '{0, 1, 2, 3, 0};
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    gnt_log.delete();
    add_job(0, 8'd48, 8'd36);
    add_job(1, 8'd35, 8'd14);
    add_job(2, 8'd17, 8'd5);
    add_job(3, 8'd100, 8'd75);
    add_job(0, 8'd48, 8'd36);
    drain("rr");
    n_vec++;
    if (gnt_log.size() != 5) begin
      n_err++; $display("FAIL rr_count: got %0d grants want 5", gnt_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if (gnt_log[i] != want[i]) begin
          n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, gnt_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_zero_operand();
    int k;
    saw_start = 1'b0;
    @(posedge clk); #1 add_job(2, 8'd0, 8'd9);
    k = 0;
    do begin @(negedge clk); k++; end while (req_ready === '0 && k < 20);
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'd9 || rsp_id !== 2'd2) begin
      n_err++; $display("FAIL zero_latency: rv=%b data=%0d id=%0d want 1/9/2", rsp_valid, rsp_data, rsp_id);
    end
    drain("zero_a");
    @(posedge clk); #1 add_job(1, 8'd0, 8'd0);
    drain("zero_ab");
    n_vec++;
    if (saw_start !== 1'b0) begin n_err++; $display("FAIL zero_nostart: gcd_start=1 seen want never"); end
  endtask

  task automatic test_backpressure();
    int k;
    logic [10:0] e;
    @(posedge clk); #1 rsp_ready = 1'b0;
    add_job(1, 8'd35, 8'd14);
    add_job(3, 8'd100, 8'd75);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    for (int c = 0; c < 10; c++) begin
      e = (exp_q.size() != 0) ? exp_q[0] : 11'h7ff;
      n_vec++;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e[10:1] || req_ready !== '0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: rv=%b id=%0d data=%0d rdy=%b want 1/%0d/%0d/0",
                 c, rsp_valid, rsp_id, rsp_data, req_ready, e[10:9], e[8:1]);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain("bp");
  endtask

  task automatic test_reset_mid_wait();
    int k;
    @(posedge clk); #1 add_job(0, 8'd255, 8'd1);
    k = 0;
    do begin @(negedge clk); k++; end while (gcd_start !== 1'b1 && k < 20);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_vec++;
    if (gcd_reset !== 1'b1) begin n_err++; $display("FAIL midrst_gcd_reset: got %b want 1", gcd_reset); end
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL midrst_idle[%0d]: busy=%b rv=%b want 0/0", c, busy, rsp_valid);
      end
    end
    @(posedge clk); #1 add_job(3, 8'd8, 8'd12);
    drain("midrst");
  endtask

`ifdef GCD_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    @(posedge clk); #1 exp_to = 1'b1;
    add_job(2, 8'd255, 8'd1);
    drain("timeout");
    n_vec++;
    if (gcd_done !== 1'b0) begin n_err++; $display("FAIL timeout_clear: gcd_done=%b want 0", gcd_done); end
    @(posedge clk); #1 add_job(1, 8'd9, 8'd6);
    drain("after_timeout");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_operand();
    test_backpressure();
    test_reset_mid_wait();
`ifdef GCD_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_rr_scheduler.md
Name: gcd_rr_scheduler

Overview:
- Shares one subtractive GCD unit among N_REQ requesters using round-robin arbitration.
- Sequences the unit's load protocol:
  - start pulse;
  - operand A on data_in;
  - operand B on data_in;
  - wait for done.
- Returns the result on a single tagged response channel, then clears the unit back to idle.
- Sits between the requester fabric and the gcd instance.

Parameters:
- SIZE, 8: operand/result width; must match the gcd unit's size.
- N_REQ, 4: number of requesters (2..16).
- ID_W, $clog2(N_REQ): width of rsp_id.
- TIMEOUT_CYCLES, 300: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*SIZE  operand A, requester i at [i*SIZE +: SIZE].
- req_b  in  N_REQ*SIZE  operand B, same packing.
- req_ready  out  N_REQ  one-hot accept pulse.
- rsp_valid  out  1  response valid.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_data  out  SIZE  GCD result.
- rsp_err  out  1  error flag; 1 only on a watchdog abort.
- rsp_ready  in  1  response consumer ready.
- gcd_start  out  1  to unit start.
- gcd_reset  out  1  to unit reset.
- gcd_data_in  out  SIZE  to unit data_in.
- gcd_data_out  in  SIZE  from unit data_out.
- gcd_done  in  1  from unit done.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - gcd_start=0, gcd_data_in=0, busy=0.
- gcd_reset = reset OR clr_q, so a system reset also drives the unit back to its idle state.
- Arbitration (IDLE only):
  - Scan from rr_ptr upward with wrap; the first i with req_valid[i]=1 wins.
  - In the same cycle, req_ready[i]=1 and {A,B,id} are latched.
  - rr_ptr <= i+1 mod N_REQ.
  - No request pending: stay in IDLE, rr_ptr unchanged.
- Zero operand bypass (operands latched with A==0 or B==0): the unit never runs, because it would not terminate.
  - Next state is RESP with rsp_data = A|B, which gives gcd(0,b)=b and gcd(0,0)=0.
  - rsp_err=0.
- States and transitions:
  - IDLE -> START on grant of nonzero operands.
  - START: gcd_start=1 for one cycle -> LDA.
  - LDA: gcd_data_in=A; the unit loads A at the end of this cycle -> LDB.
  - LDB: gcd_data_in=B -> WAIT.
  - WAIT: gcd_start=0; remain until gcd_done=1. In that cycle latch rsp_data<=gcd_data_out -> RESP.
  - RESP: rsp_valid=1 with rsp_id, rsp_data and rsp_err held stable. On rsp_valid&&rsp_ready -> CLR (bypass jobs -> IDLE).
  - CLR: clr_q=1 for one cycle, so gcd_reset pulses and the unit returns to idle -> IDLE.
- gcd_data_in holds 0 outside LDA/LDB.
- Latency:
  - grant to rsp_valid = 4 + k cycles, where k = cycles the unit spends iterating.
  - Bypass: grant to rsp_valid = 1 cycle.
- Re-grant:
  - At most one job in flight.
  - Earliest next grant is 2 cycles after the rsp handshake (CLR, then IDLE), or 1 cycle for bypass jobs.
- Requests arriving while busy are not accepted; req_valid must be held by the requester.
- A requester dropping req_valid before its grant is legal.
- Reset mid-operation, in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - The unit is cleared through gcd_reset.
  - The in-flight job is lost with no response.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro: GCD_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without gcd_done: go to RESP with rsp_data=0 and rsp_err=1, then CLR.
- Undefined:
  - No counter.
  - WAIT is unbounded.
  - rsp_err is tied 0.

Decomposition:
- Package gcd_sched_pkg:
  - state enum {IDLE, START, LDA, LDB, WAIT, RESP, CLR};
  - default SIZE/N_REQ constants;
  - ID width helper function.
- Sub-module gcd_rr_arbiter: combinational grant from req_valid and rr_ptr, plus the pointer register with its update-on-grant input.
- The FSM and operand/result registers stay in gcd_rr_scheduler.

Test Plan:
- Single job: req0 A=12, B=18 against a real gcd instance.
  - Required: gcd_start pulse, then gcd_data_in=12 then 18 on consecutive cycles.
  - Response: rsp_id=0, rsp_data=6, rsp_err=0.
  - Then a one-cycle gcd_reset pulse and busy=0.
- Round robin: all four requesters hold req_valid with (48,36), (35,14), (17,5), (100,75).
  - Required grant order 0,1,2,3,0.
  - Results 12, 7, 1, 25.
- Zero operands: (0,9) -> rsp_data=9 one cycle after grant, gcd_start never asserted. (0,0) -> rsp_data=0.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP.
  - rsp_valid, rsp_id and rsp_data stay stable.
  - No new grant while other requests are pending.
- Reset mid-WAIT: for (255,1), assert reset during WAIT.
  - Next cycle: IDLE, gcd_reset=1, no response emitted.
  - A subsequent (8,12) returns 4.
- With GCD_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20: run (255,1).
  - Required: rsp_err=1, rsp_data=0, unit cleared.
  - A following (9,6) returns 3 with rsp_err=0.
